// File: rtl/nco_freq_meter.sv
// Frequency meter for an NCO sine stream: counts rising zero crossings over a
// 2^LOG2_WIN sample window and divides the crossings by their span to recover the phase increment.
module nco_freq_meter #(
    parameter int unsigned IN_W     = 18,
    parameter int unsigned PHI_W    = 16,
    parameter int unsigned LOG2_WIN = 12,
    parameter int          HYST     = 1024
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   clken,
    input  logic                   in_valid,
    input  logic signed [IN_W-1:0] sin_i,
    output logic [PHI_W-1:0]       phi_est,
    output logic                   est_valid,
    output logic                   no_tone,
    output logic                   busy
);

    localparam int unsigned CNT_W = $clog2(PHI_W + 1);
    localparam logic [LOG2_WIN-1:0] IDX_LAST = '1;
    localparam logic [LOG2_WIN-1:0] K_MAX    = '1;
    localparam logic signed [IN_W-1:0] ARM_LVL = IN_W'(-HYST);

    typedef enum logic [1:0] {ST_ACQ, ST_DIV, ST_DONE} state_t;

    state_t              state_q, state_d;
    logic [LOG2_WIN-1:0] idx_q, idx_d;
    logic [LOG2_WIN-1:0] k_q, k_d;
    logic [LOG2_WIN-1:0] first_q, first_d;
    logic [LOG2_WIN-1:0] last_q, last_d;
    logic                armed_q, armed_d;
    logic [LOG2_WIN-1:0] rem_q, rem_d;
    logic [PHI_W:0]      lo_q, lo_d;
    logic [LOG2_WIN-1:0] den_q, den_d;
    logic [PHI_W-1:0]    quo_q, quo_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                tone_ok_q, tone_ok_d;
    logic [PHI_W-1:0]    phi_est_q, phi_est_d;
    logic                est_valid_q, est_valid_d;
    logic                no_tone_q, no_tone_d;
    logic                busy_q, busy_d;

    logic                arm_c;
    logic                cross_c;
    logic [LOG2_WIN-1:0] k_m1;
    logic [LOG2_WIN:0]   trial;
    logic                q_bit;
    logic [PHI_W:0]      quo_fin;

    // Next-state: detector/window counting in ACQ, one restoring-divide step per enabled cycle in DIV
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        k_d         = k_q;
        first_d     = first_q;
        last_d      = last_q;
        armed_d     = armed_q;
        rem_d       = rem_q;
        lo_d        = lo_q;
        den_d       = den_q;
        quo_d       = quo_q;
        cnt_d       = cnt_q;
        tone_ok_d   = tone_ok_q;
        phi_est_d   = phi_est_q;
        est_valid_d = est_valid_q;
        no_tone_d   = no_tone_q;
        busy_d      = busy_q;
        k_m1        = '0;
        trial       = '0;
        q_bit       = 1'b0;
        quo_fin     = '0;
        arm_c       = (sin_i <= ARM_LVL);
        cross_c     = armed_q && !sin_i[IN_W-1];

        if (clken) begin
            unique case (state_q)
                ST_ACQ: begin
                    if (in_valid) begin
                        idx_d = idx_q + LOG2_WIN'(1);
                        if (cross_c) begin
                            armed_d = 1'b0;
                            if (k_q != K_MAX) k_d = k_q + LOG2_WIN'(1);
                            if (k_q == '0) first_d = idx_q;
                            last_d = idx_q;
                        end else if (arm_c) begin
                            armed_d = 1'b1;
                        end
                        // Numerator (K-1)<<PHI_W: upper bits seed the remainder, bit PHI_W is shifted in first
                        if (idx_q == IDX_LAST) begin
                            state_d   = ST_DIV;
                            busy_d    = 1'b1;
                            cnt_d     = '0;
                            quo_d     = '0;
                            k_m1      = k_d - LOG2_WIN'(1);
                            rem_d     = k_m1 >> 1;
                            lo_d      = {k_m1[0], {PHI_W{1'b0}}};
                            den_d     = last_d - first_d;
                            tone_ok_d = (k_d >= LOG2_WIN'(2));
                        end
                    end
                end
                ST_DIV: begin
                    trial = {rem_q, lo_q[PHI_W]};
                    q_bit = (trial >= {1'b0, den_q});
                    rem_d = q_bit ? LOG2_WIN'(trial - {1'b0, den_q}) : LOG2_WIN'(trial);
                    lo_d  = lo_q << 1;
                    quo_d = {quo_q[PHI_W-2:0], q_bit};
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(PHI_W)) begin
                        state_d     = ST_DONE;
                        est_valid_d = 1'b1;
                        quo_fin     = {quo_q, q_bit};
                        if (!tone_ok_q) begin
                            phi_est_d = '0;
                            no_tone_d = 1'b1;
                        end else begin
                            phi_est_d = quo_fin[PHI_W] ? '1 : quo_fin[PHI_W-1:0];
                            no_tone_d = 1'b0;
                        end
                    end
                end
                ST_DONE: begin
                    state_d     = ST_ACQ;
                    busy_d      = 1'b0;
                    est_valid_d = 1'b0;
                    idx_d       = '0;
                    k_d         = '0;
                    first_d     = '0;
                    last_d      = '0;
                    armed_d     = 1'b0;
                end
                default: state_d = ST_ACQ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= ST_ACQ;
            idx_q       <= '0;
            k_q         <= '0;
            first_q     <= '0;
            last_q      <= '0;
            armed_q     <= 1'b0;
            rem_q       <= '0;
            lo_q        <= '0;
            den_q       <= '0;
            quo_q       <= '0;
            cnt_q       <= '0;
            tone_ok_q   <= 1'b0;
            phi_est_q   <= '0;
            est_valid_q <= 1'b0;
            no_tone_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            k_q         <= k_d;
            first_q     <= first_d;
            last_q      <= last_d;
            armed_q     <= armed_d;
            rem_q       <= rem_d;
            lo_q        <= lo_d;
            den_q       <= den_d;
            quo_q       <= quo_d;
            cnt_q       <= cnt_d;
            tone_ok_q   <= tone_ok_d;
            phi_est_q   <= phi_est_d;
            est_valid_q <= est_valid_d;
            no_tone_q   <= no_tone_d;
            busy_q      <= busy_d;
        end
    end

    // Pulse is held through a stalled DONE but only shown in the enabled DONE cycle
    assign est_valid = est_valid_q & clken;
    assign phi_est   = phi_est_q;
    assign no_tone   = no_tone_q;
    assign busy      = busy_q;

endmodule
